// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - Execute-stage to multiply/divide sequencer handshake and HI/LO result bundle
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic             unsigned_instr;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             abort;
  logic             stall_req;
  logic             busy;
  logic             done;
  logic             hi_write;
  logic             lo_write;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             div_by_zero;

  modport master (
    output start, op, unsigned_instr, op1, op2, abort,
    input  stall_req, busy, done, hi_write, lo_write, hi_out, lo_out, div_by_zero
  );

  modport slave (
    input  start, op, unsigned_instr, op1, op2, abort,
    output stall_req, busy, done, hi_write, lo_write, hi_out, lo_out, div_by_zero
  );
endinterface

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - Radix-2 iterative MULT/DIV sequencer producing one HI/LO write per op
// Define MDU_EARLY_OUT_EN to let multiplies leave CALC once the remaining multiplier bits are zero.
module mdu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;

  logic               valid_op, issue_req, issue, early_out, calc_last, done;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [WIDTH:0]     shifted, diff;

  assign valid_op  = (bus.op == OP_MUL) || (bus.op == OP_DIV);
  assign issue_req = (state_q == S_IDLE) && bus.start && valid_op;
  assign issue     = issue_req && !bus.abort;

  assign abs1 = (!bus.unsigned_instr && bus.op1[WIDTH-1]) ? -bus.op1 : bus.op1;
  assign abs2 = (!bus.unsigned_instr && bus.op2[WIDTH-1]) ? -bus.op2 : bus.op2;

  // Restoring divide: acc_q holds the partial remainder, opb_q shifts dividend out and quotient in.
  assign shifted = {acc_q[WIDTH-1:0], opb_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, mcand_q[WIDTH-1:0]};

`ifdef MDU_EARLY_OUT_EN
  assign early_out = !is_div_q && (opb_q[WIDTH-1:1] == '0);
`else
  assign early_out = 1'b0;
`endif

  assign calc_last = (cnt_q == '0) || early_out;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (issue) state_d = dbz_d ? S_FIX : S_CALC;
      S_CALC: if (calc_last) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort) state_d = S_IDLE;
  end

  always_comb begin
    done            = (state_q == S_DONE) && !bus.abort;
    bus.busy        = (state_q != S_IDLE);
    bus.done        = done;
    bus.hi_write    = done;
    bus.lo_write    = done;
    bus.div_by_zero = done && dbz_q;
    bus.stall_req   = issue_req || ((state_q != S_IDLE) && (state_q != S_DONE));
  end

  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    opb_d     = opb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = (bus.op == OP_DIV) && (bus.op2 == '0);
    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          is_div_d  = (bus.op == OP_DIV);
          neg_res_d = !bus.unsigned_instr && (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
          neg_rem_d = !bus.unsigned_instr && bus.op1[WIDTH-1];
          cnt_d     = CNT_W'(WIDTH - 1);
          acc_d     = '0;
          opb_d     = (bus.op == OP_DIV) ? abs1 : abs2;
          mcand_d   = {{WIDTH{1'b0}}, (bus.op == OP_DIV) ? abs2 : abs1};
        end else begin
          dbz_d = dbz_q;
        end
      end
      S_CALC: begin
        dbz_d = dbz_q;
        cnt_d = cnt_q - CNT_W'(1);
        if (is_div_q) begin
          acc_d = {{(WIDTH-1){1'b0}}, diff[WIDTH] ? shifted : diff};
          opb_d = {opb_q[WIDTH-2:0], ~diff[WIDTH]};
        end else begin
          if (opb_q[0]) acc_d = acc_q + mcand_q;
          mcand_d = mcand_q << 1;
          opb_d   = opb_q >> 1;
        end
      end
      S_FIX: begin
        dbz_d = dbz_q;
        // Results land here so hi_out/lo_out are already stable throughout the DONE cycle.
        if (!bus.abort) begin
          if (!is_div_q) begin
            {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
          end else if (dbz_q) begin
            hi_d = neg_rem_q ? -opb_q : opb_q;
            lo_d = '1;
          end else begin
            hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            lo_d = neg_res_q ? -opb_q : opb_q;
          end
        end
      end
      default: dbz_d = dbz_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      opb_q     <= opb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - Directed self-checking bench for mdu_sequencer
module tb_mdu_sequencer;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  mdu_if #(.WIDTH(32)) bus ();

  mdu_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [1:0] op, input logic uns,
                       input logic [31:0] a, input logic [31:0] b);
    bus.op = op;
    bus.unsigned_instr = uns;
    bus.op1 = a;
    bus.op2 = b;
    bus.start = 1'b1;
    #1;
    chk({tag, " issue stall"}, 64'(bus.stall_req), 64'd1);
    step();
    bus.start = 1'b0;
  endtask

  task automatic watch(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      if (bus.done) dones++;
      step();
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic uns,
                        input logic [31:0] a, input logic [31:0] b, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    int   cyc;
    logic stall_ok;
    issue(tag, op, uns, a, b);
    cyc = 1;
    stall_ok = 1'b1;
    while (!bus.done && cyc < 200) begin
      if (!bus.stall_req) stall_ok = 1'b0;
      step();
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " stall"}, 64'(stall_ok), 64'd1);
    chk({tag, " hi"}, 64'(bus.hi_out), 64'(ehi));
    chk({tag, " lo"}, 64'(bus.lo_out), 64'(elo));
    chk({tag, " dbz"}, 64'(bus.div_by_zero), 64'(edbz));
    chk({tag, " strobes"}, 64'({bus.hi_write, bus.lo_write, bus.stall_req}), 64'(3'b110));
    step();
    chk({tag, " pulse"}, 64'({bus.done, bus.busy}), 64'd0);
  endtask

  initial begin
    int   cyc;
    int   dones;
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.unsigned_instr = 1'b0;
    bus.op1 = '0;
    bus.op2 = '0;
    bus.abort = 1'b0;
    step();
    step();
    chk("reset flags", 64'({bus.busy, bus.done, bus.stall_req, bus.hi_write, bus.lo_write, bus.div_by_zero}), 64'd0);
    chk("reset hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    rst = 1'b0;
    step();

    run_op("multu max", 2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult -3*7", 2'b01, 1'b0, 32'hFFFF_FFFD, 32'd7, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult min*min", 2'b01, 1'b0, 32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0, 1'b0);
    run_op("div -7/2", 2'b10, 1'b0, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div 7/-2", 2'b10, 1'b0, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD, 1'b0);
    run_op("divu 100/7", 2'b10, 1'b1, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
    run_op("div ovf", 2'b10, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu 100/0", 2'b10, 1'b1, 32'd100, 32'd0, 2, 32'd100, 32'hFFFF_FFFF, 1'b1);
    run_op("div -100/0", 2'b10, 1'b0, 32'hFFFF_FF9C, 32'd0, 2, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1);
`ifdef MDU_EARLY_OUT_EN
    run_op("multu 5*3", 2'b01, 1'b1, 32'd5, 32'd3, 4, 32'd0, 32'd15, 1'b0);
    run_op("multu 9*0", 2'b01, 1'b1, 32'd9, 32'd0, 3, 32'd0, 32'd0, 1'b0);
`else
    run_op("multu 5*3", 2'b01, 1'b1, 32'd5, 32'd3, 34, 32'd0, 32'd15, 1'b0);
    run_op("multu 9*0", 2'b01, 1'b1, 32'd9, 32'd0, 34, 32'd0, 32'd0, 1'b0);
`endif

    // Unsupported op code must not stall or start anything.
    bus.op = 2'b11;
    bus.start = 1'b1;
    #1;
    chk("bad op stall", 64'(bus.stall_req), 64'd0);
    step();
    bus.start = 1'b0;
    chk("bad op busy", 64'(bus.busy), 64'd0);

    // A second start while busy is dropped.
    issue("busy start", 2'b01, 1'b1, 32'd6, 32'd7);
    for (cyc = 1; cyc < 5; cyc++) step();
    bus.op = 2'b10;
    bus.op1 = 32'd1;
    bus.op2 = 32'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    watch(60, dones);
    chk("busy start dones", 64'(dones), 64'd1);
    chk("busy start result", {bus.hi_out, bus.lo_out}, 64'd42);
    chk("busy start idle", 64'(bus.busy), 64'd0);

    // Abort mid-calculation.
    issue("abort calc", 2'b01, 1'b1, 32'd11, 32'd13);
    for (cyc = 1; cyc < 10; cyc++) step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort calc busy", 64'(bus.busy), 64'd0);
    watch(40, dones);
    chk("abort calc dones", 64'(dones), 64'd0);

    // Abort in the DONE cycle masks the pulse and strobes.
    issue("abort done", 2'b01, 1'b1, 32'd2, 32'd3);
    cyc = 1;
    while (!bus.done && cyc < 200) begin
      step();
      cyc++;
    end
    chk("abort done reached", 64'(bus.done), 64'd1);
    bus.abort = 1'b1;
    #1;
    chk("abort done strobes", 64'({bus.done, bus.hi_write, bus.lo_write, bus.div_by_zero}), 64'd0);
    step();
    bus.abort = 1'b0;
    chk("abort done idle", 64'({bus.busy, bus.done}), 64'd0);

    // Reset mid-op clears everything and writes nothing.
    issue("reset mid", 2'b01, 1'b0, 32'hFFFF_FFFD, 32'd7);
    for (cyc = 1; cyc < 20; cyc++) step();
    rst = 1'b1;
    step();
    chk("reset mid flags", 64'({bus.busy, bus.done, bus.stall_req, bus.hi_write, bus.lo_write, bus.div_by_zero}), 64'd0);
    chk("reset mid hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    rst = 1'b0;
    watch(40, dones);
    chk("reset mid dones", 64'(dones), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
